matrix_slot_allocator: RTL and testbench

//  Owns matrix storage memory: hands out base addresses to the UART input/generator path, keeps a

---
 rtl/matrix_mem_pkg.sv | 44 ++++
 rtl/matrix_slot_table.sv | 47 ++++
 rtl/matrix_slot_allocator.sv | 225 ++++++++++++++++++++++
 tb/tb_matrix_slot_allocator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mem_pkg.sv
// rtl/matrix_mem_pkg.sv - shared constants, state encoding and slot entry types for matrix storage
package matrix_mem_pkg;

    localparam int NUM_SLOTS   = 9;
    localparam int SLOT_WORDS  = 27;
    localparam int MAX_PER_DIM = 2;
    localparam int DIM_MAX     = 5;

    localparam int IDX_W   = 4;
    localparam int DIM_W   = 3;
    localparam int STAMP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE,
        ST_GRANT,
        ST_COOL,
        ST_LOOKUP
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [DIM_W-1:0]   m;
        logic [DIM_W-1:0]   n;
        logic [STAMP_W-1:0] stamp;
    } slot_entry_t;

    typedef struct packed {
        logic               free_found;
        logic [IDX_W-1:0]   free_idx;
        logic [IDX_W-1:0]   same_cnt;
        logic [IDX_W-1:0]   same_idx;
        logic [STAMP_W-1:0] same_age;
        logic               old_found;
        logic [IDX_W-1:0]   old_idx;
        logic [STAMP_W-1:0] old_age;
    } scan_track_t;

    function automatic logic [7:0] slot_base(input logic [IDX_W-1:0] idx);
        return 8'(idx) * 8'(SLOT_WORDS);
    endfunction

endpackage

// File: rtl/matrix_slot_table.sv
// rtl/matrix_slot_table.sv - slot directory register file: one write port, scan and lookup read ports
module matrix_slot_table
    import matrix_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  slot_entry_t      wdata_i,
    input  logic [IDX_W-1:0] scan_addr_i,
    output slot_entry_t      scan_data_o,
    input  logic [IDX_W-1:0] lookup_addr_i,
    output logic             lookup_valid_o,
    output logic [DIM_W-1:0] lookup_m_o,
    output logic [DIM_W-1:0] lookup_n_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    slot_entry_t entry_q [NUM_SLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) entry_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) entry_q[i] <= '0;
        end else if (we_i && waddr_i <= LAST_IDX) begin
            entry_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range addresses read as an empty entry.
    always_comb begin
        scan_data_o    = '0;
        lookup_valid_o = 1'b0;
        lookup_m_o     = '0;
        lookup_n_o     = '0;
        if (scan_addr_i <= LAST_IDX) scan_data_o = entry_q[scan_addr_i];
        if (lookup_addr_i <= LAST_IDX) begin
            lookup_valid_o = entry_q[lookup_addr_i].valid;
            lookup_m_o     = entry_q[lookup_addr_i].m;
            lookup_n_o     = entry_q[lookup_addr_i].n;
        end
    end

endmodule

// File: rtl/matrix_slot_allocator.sv
// rtl/matrix_slot_allocator.sv - hands out matrix slot base addresses with per-dimension quota and oldest-first eviction
module matrix_slot_allocator
    import matrix_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    input  logic [DIM_W-1:0] alloc_m,
    input  logic [DIM_W-1:0] alloc_n,
    output logic             alloc_grant,
    output logic [7:0]       alloc_base,
    output logic [IDX_W-1:0] alloc_id,
    output logic             alloc_err,
    input  logic             lookup_req,
    input  logic [IDX_W-1:0] lookup_id,
    output logic             lookup_valid,
    output logic             lookup_hit,
    output logic [7:0]       lookup_base,
    output logic [DIM_W-1:0] lookup_m,
    output logic [DIM_W-1:0] lookup_n,
    input  logic             clear_all,
    output logic [IDX_W-1:0] num_valid,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic               victim_free_q, victim_free_d;
    logic [DIM_W-1:0]   m_q, m_d, n_q, n_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    scan_track_t        trk_q, trk_d;

    logic               grant_q, grant_d, err_q, err_d;
    logic [7:0]         base_q, base_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               lk_valid_q, lk_valid_d, lk_hit_q, lk_hit_d;
    logic [7:0]         lk_base_q, lk_base_d;
    logic [DIM_W-1:0]   lk_m_q, lk_m_d, lk_n_q, lk_n_d;
    logic [IDX_W-1:0]   num_valid_q, num_valid_d;

    slot_entry_t        scan_entry, wr_entry;
    logic               tbl_we, tbl_clear;
    logic               tbl_lk_valid;
    logic [DIM_W-1:0]   tbl_lk_m, tbl_lk_n;
    logic [IDX_W-1:0]   lk_addr;
    logic               lk_in_range, lk_is_hit;
    logic [STAMP_W-1:0] age;
    logic               dims_legal, same_dims;

    assign lk_in_range = (lookup_id != '0) && (lookup_id <= IDX_W'(NUM_SLOTS));
    assign lk_addr     = lookup_id - IDX_W'(1);
    assign lk_is_hit   = lk_in_range && tbl_lk_valid;
    assign dims_legal  = (alloc_m != '0) && (alloc_m <= DIM_W'(DIM_MAX)) &&
                         (alloc_n != '0) && (alloc_n <= DIM_W'(DIM_MAX));
    assign age         = stamp_q - scan_entry.stamp;
    assign same_dims   = (scan_entry.m == m_q) && (scan_entry.n == n_q);
    assign wr_entry    = '{valid: 1'b1, m: m_q, n: n_q, stamp: stamp_q};

    matrix_slot_table u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (tbl_clear),
        .we_i           (tbl_we),
        .waddr_i        (victim_q),
        .wdata_i        (wr_entry),
        .scan_addr_i    (scan_idx_q),
        .scan_data_o    (scan_entry),
        .lookup_addr_i  (lk_addr),
        .lookup_valid_o (tbl_lk_valid),
        .lookup_m_o     (tbl_lk_m),
        .lookup_n_o     (tbl_lk_n)
    );

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        victim_d      = victim_q;
        victim_free_d = victim_free_q;
        m_d           = m_q;
        n_d           = n_q;
        stamp_d       = stamp_q;
        trk_d         = trk_q;
        grant_d       = 1'b0;
        err_d         = 1'b0;
        base_d        = base_q;
        id_d          = id_q;
        lk_valid_d    = 1'b0;
        lk_hit_d      = lk_hit_q;
        lk_base_d     = lk_base_q;
        lk_m_d        = lk_m_q;
        lk_n_d        = lk_n_q;
        num_valid_d   = num_valid_q;
        tbl_we        = 1'b0;
        tbl_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    tbl_clear   = 1'b1;
                    num_valid_d = '0;
                end else if (lookup_req) begin
                    state_d    = ST_LOOKUP;
                    lk_valid_d = 1'b1;
                    lk_hit_d   = lk_is_hit;
                    lk_base_d  = lk_is_hit ? slot_base(lk_addr) : 8'd0;
                    lk_m_d     = lk_is_hit ? tbl_lk_m : '0;
                    lk_n_d     = lk_is_hit ? tbl_lk_n : '0;
                end else if (alloc_req) begin
                    m_d = alloc_m;
                    n_d = alloc_n;
                    if (dims_legal) begin
                        state_d    = ST_SCAN;
                        scan_idx_d = '0;
                        trk_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Strict '>' keeps the lower index on equal age.
                if (scan_entry.valid) begin
                    if (same_dims) begin
                        trk_d.same_cnt = trk_q.same_cnt + IDX_W'(1);
                        if (trk_q.same_cnt == '0 || age > trk_q.same_age) begin
                            trk_d.same_idx = scan_idx_q;
                            trk_d.same_age = age;
                        end
                    end
                    if (!trk_q.old_found || age > trk_q.old_age) begin
                        trk_d.old_found = 1'b1;
                        trk_d.old_idx   = scan_idx_q;
                        trk_d.old_age   = age;
                    end
                end else if (!trk_q.free_found) begin
                    trk_d.free_found = 1'b1;
                    trk_d.free_idx   = scan_idx_q;
                end
                if (scan_idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = ST_DECIDE;
                else scan_idx_d = scan_idx_q + IDX_W'(1);
            end
            ST_DECIDE: begin
                if (trk_q.same_cnt >= IDX_W'(MAX_PER_DIM)) begin
                    victim_d      = trk_q.same_idx;
                    victim_free_d = 1'b0;
                end else if (trk_q.free_found) begin
                    victim_d      = trk_q.free_idx;
                    victim_free_d = 1'b1;
                end else begin
                    victim_d      = trk_q.old_idx;
                    victim_free_d = 1'b0;
                end
                grant_d = 1'b1;
                base_d  = slot_base(victim_d);
                id_d    = victim_d + IDX_W'(1);
                state_d = ST_GRANT;
            end
            ST_GRANT: begin
                tbl_we  = 1'b1;
                stamp_d = stamp_q + STAMP_W'(1);
                if (victim_free_q) num_valid_d = num_valid_q + IDX_W'(1);
                state_d = ST_COOL;
            end
            ST_COOL:   state_d = ST_IDLE;
            ST_LOOKUP: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            scan_idx_q    <= '0;
            victim_q      <= '0;
            victim_free_q <= 1'b0;
            m_q           <= '0;
            n_q           <= '0;
            stamp_q       <= '0;
            trk_q         <= '0;
            grant_q       <= 1'b0;
            err_q         <= 1'b0;
            base_q        <= '0;
            id_q          <= '0;
            lk_valid_q    <= 1'b0;
            lk_hit_q      <= 1'b0;
            lk_base_q     <= '0;
            lk_m_q        <= '0;
            lk_n_q        <= '0;
            num_valid_q   <= '0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            victim_q      <= victim_d;
            victim_free_q <= victim_free_d;
            m_q           <= m_d;
            n_q           <= n_d;
            stamp_q       <= stamp_d;
            trk_q         <= trk_d;
            grant_q       <= grant_d;
            err_q         <= err_d;
            base_q        <= base_d;
            id_q          <= id_d;
            lk_valid_q    <= lk_valid_d;
            lk_hit_q      <= lk_hit_d;
            lk_base_q     <= lk_base_d;
            lk_m_q        <= lk_m_d;
            lk_n_q        <= lk_n_d;
            num_valid_q   <= num_valid_d;
        end
    end

    assign alloc_grant  = grant_q;
    assign alloc_base   = base_q;
    assign alloc_id     = id_q;
    assign alloc_err    = err_q;
    assign lookup_valid = lk_valid_q;
    assign lookup_hit   = lk_hit_q;
    assign lookup_base  = lk_base_q;
    assign lookup_m     = lk_m_q;
    assign lookup_n     = lk_n_q;
    assign num_valid    = num_valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// tb/tb_matrix_slot_allocator.sv - self-checking bench for matrix_slot_allocator
module tb_matrix_slot_allocator;

    localparam int SW = 27;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic [2:0] alloc_m, alloc_n;
    logic       alloc_grant;
    logic [7:0] alloc_base;
    logic [3:0] alloc_id;
    logic       alloc_err;
    logic       lookup_req;
    logic [3:0] lookup_id;
    logic       lookup_valid, lookup_hit;
    logic [7:0] lookup_base;
    logic [2:0] lookup_m, lookup_n;
    logic       clear_all;
    logic [3:0] num_valid;
    logic       busy;

    matrix_slot_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_m      (alloc_m),
        .alloc_n      (alloc_n),
        .alloc_grant  (alloc_grant),
        .alloc_base   (alloc_base),
        .alloc_id     (alloc_id),
        .alloc_err    (alloc_err),
        .lookup_req   (lookup_req),
        .lookup_id    (lookup_id),
        .lookup_valid (lookup_valid),
        .lookup_hit   (lookup_hit),
        .lookup_base  (lookup_base),
        .lookup_m     (lookup_m),
        .lookup_n     (lookup_n),
        .clear_all    (clear_all),
        .num_valid    (num_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [2:0] n;
        bit         err;
        logic [7:0] base;
        logic [3:0] id;
        logic [3:0] nv;
    } alloc_vec_t;

    typedef struct {
        logic [3:0] id;
        logic       hit;
        logic [7:0] base;
        logic [2:0] m;
        logic [2:0] n;
    } lk_vec_t;

    typedef struct {
        logic [7:0] base;
        logic [3:0] id;
    } grant_t;

    grant_t     sb_q[$];
    alloc_vec_t seq1 [5];
    alloc_vec_t fillv[9];
    lk_vec_t    lkv  [5];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_alloc(input logic [2:0] m, input logic [2:0] n,
                            input logic [7:0] eb, input logic [3:0] eid, input bit drop_early);
        int     cyc;
        bit     seen;
        grant_t g;
        sb_q.push_back('{base: eb, id: eid});
        @(negedge clk);
        alloc_req = 1'b1;
        alloc_m   = m;
        alloc_n   = n;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (drop_early && cyc == 3) alloc_req = 1'b0;
            if (alloc_grant) seen = 1;
        end
        g = sb_q.pop_front();
        check("grant_seen", 32'(seen), 1);
        if (seen) begin
            check("grant_latency", 32'(cyc), 11);
            check("grant_base", 32'(alloc_base), 32'(g.base));
            check("grant_id", 32'(alloc_id), 32'(g.id));
            @(negedge clk);
            check("grant_pulse_end", 32'(alloc_grant), 0);
            check("grant_base_hold", 32'(alloc_base), 32'(g.base));
            @(negedge clk);
            check("cool_no_reaccept", 32'(busy), 0);
        end
        alloc_req = 1'b0;
    endtask

    task automatic do_err(input logic [2:0] m, input logic [2:0] n);
        @(negedge clk);
        alloc_req = 1'b1;
        alloc_m   = m;
        alloc_n   = n;
        @(negedge clk);
        alloc_req = 1'b0;
        check("err_pulse", 32'(alloc_err), 1);
        check("err_no_grant", 32'(alloc_grant), 0);
        check("err_stay_idle", 32'(busy), 0);
        @(negedge clk);
        check("err_pulse_end", 32'(alloc_err), 0);
    endtask

    task automatic do_lookup(input lk_vec_t v);
        @(negedge clk);
        lookup_req = 1'b1;
        lookup_id  = v.id;
        @(negedge clk);
        lookup_req = 1'b0;
        check("lk_valid", 32'(lookup_valid), 1);
        check("lk_hit", 32'(lookup_hit), 32'(v.hit));
        check("lk_base", 32'(lookup_base), 32'(v.base));
        check("lk_m", 32'(lookup_m), 32'(v.m));
        check("lk_n", 32'(lookup_n), 32'(v.n));
        @(negedge clk);
        check("lk_valid_end", 32'(lookup_valid), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(alloc_grant), 0);
        check({tag, "_base"}, 32'(alloc_base), 0);
        check({tag, "_id"}, 32'(alloc_id), 0);
        check({tag, "_err"}, 32'(alloc_err), 0);
        check({tag, "_lkv"}, 32'(lookup_valid), 0);
        check({tag, "_lkhit"}, 32'(lookup_hit), 0);
        check({tag, "_lkbase"}, 32'(lookup_base), 0);
        check({tag, "_nv"}, 32'(num_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        seq1[0] = '{m: 3'd2, n: 3'd3, err: 0, base: 8'd0,  id: 4'd1, nv: 4'd1};
        seq1[1] = '{m: 3'd2, n: 3'd3, err: 0, base: 8'd27, id: 4'd2, nv: 4'd2};
        seq1[2] = '{m: 3'd2, n: 3'd3, err: 0, base: 8'd0,  id: 4'd1, nv: 4'd2};
        seq1[3] = '{m: 3'd6, n: 3'd1, err: 1, base: 8'd0,  id: 4'd0, nv: 4'd2};
        seq1[4] = '{m: 3'd3, n: 3'd0, err: 1, base: 8'd0,  id: 4'd0, nv: 4'd2};
        for (int k = 0; k < 9; k++) begin
            fillv[k].m    = (k < 5) ? 3'd1 : 3'd2;
            fillv[k].n    = (k < 5) ? 3'(k + 1) : 3'(k - 4);
            fillv[k].err  = 0;
            fillv[k].base = 8'(k * SW);
            fillv[k].id   = 4'(k + 1);
            fillv[k].nv   = 4'(k + 1);
        end
        lkv[0] = '{id: 4'd2,  hit: 1'b1, base: 8'd27, m: 3'd2, n: 3'd3};
        lkv[1] = '{id: 4'd1,  hit: 1'b1, base: 8'd0,  m: 3'd2, n: 3'd3};
        lkv[2] = '{id: 4'd0,  hit: 1'b0, base: 8'd0,  m: 3'd0, n: 3'd0};
        lkv[3] = '{id: 4'd10, hit: 1'b0, base: 8'd0,  m: 3'd0, n: 3'd0};
        lkv[4] = '{id: 4'd3,  hit: 1'b0, base: 8'd0,  m: 3'd0, n: 3'd0};

        rst_n      = 1'b0;
        alloc_req  = 1'b0;
        alloc_m    = 3'd0;
        alloc_n    = 3'd0;
        lookup_req = 1'b0;
        lookup_id  = 4'd0;
        clear_all  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (seq1[i].err) do_err(seq1[i].m, seq1[i].n);
            else do_alloc(seq1[i].m, seq1[i].n, seq1[i].base, seq1[i].id, 0);
            check("seq1_num_valid", 32'(num_valid), 32'(seq1[i].nv));
        end

        for (int i = 0; i < 5; i++) do_lookup(lkv[i]);

        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("clear_num_valid", 32'(num_valid), 0);
        do_lookup('{id: 4'd2, hit: 1'b0, base: 8'd0, m: 3'd0, n: 3'd0});

        for (int i = 0; i < 9; i++) begin
            do_alloc(fillv[i].m, fillv[i].n, fillv[i].base, fillv[i].id, 0);
            check("fill_num_valid", 32'(num_valid), 32'(fillv[i].nv));
        end
        do_alloc(3'd4, 3'd4, 8'd0, 4'd1, 0);
        check("evict_num_valid", 32'(num_valid), 9);
        do_lookup('{id: 4'd1, hit: 1'b1, base: 8'd0, m: 3'd4, n: 3'd4});

        // Request dropped mid-scan still completes; oldest remaining is slot 1.
        do_alloc(3'd3, 3'd3, 8'd27, 4'd2, 1);
        check("drop_num_valid", 32'(num_valid), 9);

        @(negedge clk);
        alloc_req = 1'b1;
        alloc_m   = 3'd5;
        alloc_n   = 3'd5;
        repeat (5) @(negedge clk);
        check("scan_busy", 32'(busy), 1);
        rst_n     = 1'b0;
        alloc_req = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_lookup('{id: 4'd1, hit: 1'b0, base: 8'd0, m: 3'd0, n: 3'd0});
        do_lookup('{id: 4'd9, hit: 1'b0, base: 8'd0, m: 3'd0, n: 3'd0});
        do_alloc(3'd2, 3'd3, 8'd0, 4'd1, 0);
        check("post_reset_num_valid", 32'(num_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
